// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter
//   Shares one Avalon-MM master port between the instruction-fetch unit (read-only)
//   and the load/store unit (read/write). Transfers are issued from registered master
//   outputs, stalled by the slave's waitrequest, and answered to the requester with a
//   one-cycle done pulse. Grants alternate round-robin on a tie. A watchdog aborts a
//   transfer whose waitrequest stays high too long.
module mips_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ABORT_DATA     = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,

    // instruction-fetch requester
    input  logic        i_read,
    input  logic [31:0] i_address,
    output logic [31:0] i_readdata,
    output logic        i_waitrequest,

    // load/store requester
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_address,
    input  logic [3:0]  d_byteenable,
    input  logic [31:0] d_writedata,
    output logic [31:0] d_readdata,
    output logic        d_waitrequest,

    // Avalon-MM master
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic [31:0] readdata,
    input  logic        waitrequest,

    output logic        bus_error
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2
    } state_t;

    // A zero timeout disables the watchdog; the timer still runs but never fires.
    localparam bit          WD_EN      = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [15:0] TIMER_MAX  = 16'hFFFF;

    // last_grant: 0 = fetch, 1 = data. Reset to data so fetch wins the first tie.
    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        i_done_q, i_done_d;
    logic        d_done_q, d_done_d;
    logic [15:0] timer_q, timer_d;
    logic [31:0] address_q, address_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [3:0]  byteenable_q, byteenable_d;
    logic [31:0] writedata_q, writedata_d;
    logic [31:0] i_readdata_q, i_readdata_d;
    logic [31:0] d_readdata_q, d_readdata_d;
    logic        bus_error_q, bus_error_d;

    logic        busy;
    logic        stall;
    logic        timeout_hit;
    logic        xfer_end;
    logic        i_elig;
    logic        d_elig;
    logic        arb_open;
    logic        grant_i;
    logic        grant_d;
    logic [31:0] cap_data;

    // Transfer status and round-robin arbitration decision for this edge.
    always_comb begin
        busy        = (state_q != ST_IDLE);
        stall       = busy & waitrequest;
        timeout_hit = WD_EN & stall & (timer_q == TIMER_LAST);
        xfer_end    = busy & (~waitrequest | timeout_hit);

        // The requester being served is ineligible on its own completion edge, so a
        // back-to-back grant can only go to the other side.
        i_elig   = i_read & ~i_done_q & (state_q != ST_GRANT_I);
        d_elig   = (d_read | d_write) & ~d_done_q & (state_q != ST_GRANT_D);
        arb_open = ~busy | xfer_end;

        grant_i  = arb_open & i_elig & (~d_elig | last_grant_q);
        grant_d  = arb_open & d_elig & ~grant_i;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a grant always wins; otherwise a finished transfer returns to idle.
    always_comb begin
        state_d = state_q;
        if (grant_i) begin
            state_d = ST_GRANT_I;
        end else if (grant_d) begin
            state_d = ST_GRANT_D;
        end else if (xfer_end) begin
            state_d = ST_IDLE;
        end
    end

    // Output/datapath next values: load master on grant, capture on completion or abort.
    always_comb begin
        last_grant_d = last_grant_q;
        address_d    = address_q;
        read_d       = read_q;
        write_d      = write_q;
        byteenable_d = byteenable_q;
        writedata_d  = writedata_q;
        i_readdata_d = i_readdata_q;
        d_readdata_d = d_readdata_q;
        timer_d      = timer_q;
        bus_error_d  = bus_error_q | timeout_hit;
        i_done_d     = xfer_end & (state_q == ST_GRANT_I);
        d_done_d     = xfer_end & (state_q == ST_GRANT_D);

        // waitrequest is still high only when the watchdog fired.
        cap_data = waitrequest ? ABORT_DATA : readdata;

        if (xfer_end) begin
            read_d  = 1'b0;
            write_d = 1'b0;
            if (read_q) begin
                if (state_q == ST_GRANT_I) begin
                    i_readdata_d = cap_data;
                end else begin
                    d_readdata_d = cap_data;
                end
            end
        end

        if (stall && (timer_q != TIMER_MAX)) begin
            timer_d = timer_q + 16'd1;
        end

        if (grant_i) begin
            address_d    = i_address;
            byteenable_d = 4'b1111;
            read_d       = 1'b1;
            write_d      = 1'b0;
            last_grant_d = 1'b0;
            timer_d      = 16'd0;
        end else if (grant_d) begin
            // A simultaneous read and write request is resolved as a write and flagged.
            address_d    = d_address;
            byteenable_d = d_byteenable;
            writedata_d  = d_writedata;
            write_d      = d_write;
            read_d       = d_read & ~d_write;
            last_grant_d = 1'b1;
            timer_d      = 16'd0;
            bus_error_d  = bus_error_q | timeout_hit | (d_read & d_write);
        end
    end

    // Datapath and handshake registers; reset drops any transfer in flight at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            timer_q      <= 16'd0;
            address_q    <= 32'd0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            byteenable_q <= 4'd0;
            writedata_q  <= 32'd0;
            i_readdata_q <= 32'd0;
            d_readdata_q <= 32'd0;
            bus_error_q  <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
            timer_q      <= timer_d;
            address_q    <= address_d;
            read_q       <= read_d;
            write_q      <= write_d;
            byteenable_q <= byteenable_d;
            writedata_q  <= writedata_d;
            i_readdata_q <= i_readdata_d;
            d_readdata_q <= d_readdata_d;
            bus_error_q  <= bus_error_d;
        end
    end

    assign i_waitrequest = i_read & ~i_done_q;
    assign d_waitrequest = (d_read | d_write) & ~d_done_q;
    assign i_readdata    = i_readdata_q;
    assign d_readdata    = d_readdata_q;
    assign address       = address_q;
    assign read          = read_q;
    assign write         = write_q;
    assign byteenable    = byteenable_q;
    assign writedata     = writedata_q;
    assign bus_error     = bus_error_q;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Testbench for mips_bus_arbiter: directed cycle checks, then two random requesters
// against a behavioural slave, with expected responses queued at issue time.
module tb_mips_bus_arbiter;

    localparam int          TO    = 8;
    localparam logic [31:0] ABORT = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_read = 1'b0;
    logic [31:0] i_address = 32'd0;
    logic [31:0] i_readdata;
    logic        i_waitrequest;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [31:0] d_address = 32'd0;
    logic [3:0]  d_byteenable = 4'd0;
    logic [31:0] d_writedata = 32'd0;
    logic [31:0] d_readdata;
    logic        d_waitrequest;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        bus_error;

    // Slave side: directed values while sb_en=0, behavioural slave otherwise.
    logic        sb_en = 1'b0;
    logic        dir_wait = 1'b0;
    logic [31:0] dir_rdata = 32'd0;
    logic        slv_wait;
    logic [31:0] slv_rdata;
    assign waitrequest = sb_en ? slv_wait : dir_wait;
    assign readdata    = sb_en ? slv_rdata : dir_rdata;

    mips_bus_arbiter #(.TIMEOUT_CYCLES(TO), .ABORT_DATA(ABORT)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata),
        .i_waitrequest(i_waitrequest),
        .d_read(d_read), .d_write(d_write), .d_address(d_address),
        .d_byteenable(d_byteenable), .d_writedata(d_writedata),
        .d_readdata(d_readdata), .d_waitrequest(d_waitrequest),
        .address(address), .read(read), .write(write), .byteenable(byteenable),
        .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
        .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit exp_err = 1'b0;

    // kind: 0 read, 1 write, 2 read+write (seen on the bus as a write)
    typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; int kind; int stall; } req_t;
    typedef struct { logic [31:0] data; bit is_read; bit aborted; bit both; } rsp_t;
    req_t i_slv_q[$];
    req_t d_slv_q[$];
    rsp_t i_exp_q[$];
    rsp_t d_exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    // Mostly short stalls, some 5-cycle stalls, occasionally a hang past the watchdog.
    function automatic int pick_stall();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 14) return r % 4;
        if (r < 18) return 5;
        return 12;
    endfunction

    task automatic wait_done_i();
        int wt;
        wt = 0;
        do begin @(negedge clk); wt++; end while (i_waitrequest && wt < 300);
        if (i_waitrequest) begin
            tests++; fails++;
            $display("FAIL i_done_timeout: got no completion within %0d cycles", wt);
        end
    endtask

    task automatic wait_done_d();
        int wt;
        wt = 0;
        do begin @(negedge clk); wt++; end while (d_waitrequest && wt < 300);
        if (d_waitrequest) begin
            tests++; fails++;
            $display("FAIL d_done_timeout: got no completion within %0d cycles", wt);
        end
    endtask

    task automatic run_i(input int n);
        for (int k = 0; k < n; k++) begin
            req_t rq;
            rsp_t rs;
            int   gap;
            rq.addr  = {1'b1, 29'($urandom), 2'b00};
            rq.be    = 4'b1111;
            rq.wdata = 32'd0;
            rq.kind  = 0;
            rq.stall = pick_stall();
            rs.is_read = 1'b1;
            rs.both    = 1'b0;
            rs.aborted = (rq.stall >= TO);
            rs.data    = rs.aborted ? ABORT : mem_fn(rq.addr);
            if (rs.aborted) exp_err = 1'b1;
            i_slv_q.push_back(rq);
            i_exp_q.push_back(rs);
            i_address = rq.addr;
            i_read    = 1'b1;
            wait_done_i();
            @(posedge clk); #1;
            gap = int'($urandom_range(0, 2));
            if (gap > 0) begin
                i_read = 1'b0;
                repeat (gap) begin @(posedge clk); #1; end
            end
        end
        i_read = 1'b0;
    endtask

    task automatic run_d(input int n);
        for (int k = 0; k < n; k++) begin
            req_t rq;
            rsp_t rs;
            int   r;
            int   gap;
            r = int'($urandom_range(0, 9));
            rq.kind  = (r < 5) ? 0 : ((r < 9) ? 1 : 2);
            rq.addr  = {1'b0, 31'($urandom)};
            rq.be    = 4'($urandom_range(1, 15));
            rq.wdata = $urandom;
            rq.stall = pick_stall();
            rs.is_read = (rq.kind == 0);
            rs.both    = (rq.kind == 2);
            rs.aborted = (rq.stall >= TO);
            rs.data    = rs.aborted ? ABORT : mem_fn(rq.addr);
            if (rs.aborted || rs.both) exp_err = 1'b1;
            d_slv_q.push_back(rq);
            d_exp_q.push_back(rs);
            d_address    = rq.addr;
            d_byteenable = rq.be;
            d_writedata  = rq.wdata;
            d_read       = (rq.kind != 1);
            d_write      = (rq.kind != 0);
            wait_done_d();
            @(posedge clk); #1;
            gap = int'($urandom_range(0, 2));
            if (gap > 0) begin
                d_read  = 1'b0;
                d_write = 1'b0;
                repeat (gap) begin @(posedge clk); #1; end
            end
        end
        d_read  = 1'b0;
        d_write = 1'b0;
    endtask

    // Behavioural slave: checks each new master transfer against the issuing
    // requester's record, holds waitrequest for that record's stall count, and
    // treats a transfer as abandoned after TO stalled edges.
    initial begin
        bit   busy;
        int   stalls;
        req_t cur;
        logic [1:0] exp_rw;
        busy = 1'b0; stalls = 0; slv_wait = 1'b0; slv_rdata = 32'd0;
        cur.addr = 32'd0; cur.be = 4'd0; cur.wdata = 32'd0; cur.kind = 0; cur.stall = 0;
        exp_rw = 2'b00;
        forever begin
            @(posedge clk); #1;
            if (!sb_en || !reset) begin
                busy = 1'b0;
                slv_wait = 1'b0;
            end else begin
                if (busy) begin
                    if (!slv_wait) begin
                        busy = 1'b0;
                    end else begin
                        stalls++;
                        if (stalls >= TO) busy = 1'b0;
                    end
                end
                if (busy) begin
                    chk("hold_address", address, cur.addr);
                    chk("hold_strobes", 32'({read, write}), 32'(exp_rw));
                end else if (read || write) begin
                    if (address[31] ? (i_slv_q.size() == 0) : (d_slv_q.size() == 0)) begin
                        tests++; fails++;
                        $display("FAIL bus_unexpected: got transfer to %h with no request outstanding", address);
                    end else begin
                        if (address[31]) cur = i_slv_q.pop_front();
                        else             cur = d_slv_q.pop_front();
                        busy   = 1'b1;
                        stalls = 0;
                        exp_rw = (cur.kind == 0) ? 2'b10 : 2'b01;
                        chk("bus_address", address, cur.addr);
                        chk("bus_byteenable", 32'(byteenable), 32'(cur.be));
                        chk("bus_strobes", 32'({read, write}), 32'(exp_rw));
                        if (cur.kind != 0) chk("bus_writedata", writedata, cur.wdata);
                    end
                end
                slv_wait  = busy && (stalls < cur.stall);
                slv_rdata = mem_fn(address);
            end
        end
    end

    // Monitor: pops the expected response whenever a requester sees its done pulse.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (sb_en) begin
                if (i_read && !i_waitrequest) begin
                    if (i_exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL i_unexpected_done: got completion with nothing expected");
                    end else begin
                        r = i_exp_q.pop_front();
                        chk("i_readdata", i_readdata, r.data);
                        if (r.aborted) chk("i_abort_bus_error", 32'(bus_error), 32'd1);
                    end
                end
                if ((d_read || d_write) && !d_waitrequest) begin
                    if (d_exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL d_unexpected_done: got completion with nothing expected");
                    end else begin
                        r = d_exp_q.pop_front();
                        if (r.is_read) chk("d_readdata", d_readdata, r.data);
                        if (r.aborted || r.both) chk("d_bus_error", 32'(bus_error), 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, required finish before %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_address", address, 32'd0);
        chk("rst_read", 32'(read), 32'd0);
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_byteenable", 32'(byteenable), 32'd0);
        chk("rst_writedata", writedata, 32'd0);
        chk("rst_i_readdata", i_readdata, 32'd0);
        chk("rst_d_readdata", d_readdata, 32'd0);
        chk("rst_bus_error", 32'(bus_error), 32'd0);
        reset = 1'b1;

        // Minimum-latency fetch
        i_address = 32'hBFC00000; i_read = 1'b1; dir_rdata = 32'h8C010064; dir_wait = 1'b0;
        @(posedge clk); #1;
        chk("t1_read", 32'(read), 32'd1);
        chk("t1_address", address, 32'hBFC00000);
        chk("t1_byteenable", 32'(byteenable), 32'hF);
        @(negedge clk);
        chk("t1_wait_cycle1", 32'(i_waitrequest), 32'd1);
        @(posedge clk); #1;
        chk("t1_wait_cycle2", 32'(i_waitrequest), 32'd0);
        chk("t1_i_readdata", i_readdata, 32'h8C010064);
        chk("t1_read_dropped", 32'(read), 32'd0);
        @(posedge clk); #1;
        chk("t1_done_one_cycle", 32'(i_waitrequest), 32'd1);
        chk("t1_no_regrant", 32'(read), 32'd0);
        i_read = 1'b0;

        // Stalled write, async reset mid-transfer, then fetch wins the tie
        d_address = 32'd200; d_writedata = 32'd123; d_byteenable = 4'b1111; d_write = 1'b1;
        dir_wait = 1'b1;
        @(posedge clk); #1;
        chk("t5_write", 32'(write), 32'd1);
        chk("t5_address", address, 32'd200);
        chk("t5_writedata", writedata, 32'd123);
        @(posedge clk); #1;
        chk("t5_write_held", 32'(write), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t5_rst_write", 32'(write), 32'd0);
        chk("t5_rst_read", 32'(read), 32'd0);
        chk("t5_rst_address", address, 32'd0);
        chk("t5_rst_no_done", 32'(d_waitrequest), 32'd1);
        i_address = 32'hBFC00004; i_read = 1'b1;
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("t2_fetch_first", 32'({read, write}), 32'b10);
        chk("t2_fetch_addr", address, 32'hBFC00004);
        dir_wait = 1'b0; dir_rdata = 32'h11223344;
        @(posedge clk); #1;
        chk("t2_fetch_done", 32'(i_waitrequest), 32'd0);
        chk("t2_fetch_data", i_readdata, 32'h11223344);
        chk("t2_b2b_write", 32'({read, write}), 32'b01);
        chk("t2_b2b_addr", address, 32'd200);
        chk("t2_b2b_be", 32'(byteenable), 32'hF);
        @(posedge clk); #1;
        chk("t2_write_done", 32'(d_waitrequest), 32'd0);
        chk("t2_write_dropped", 32'(write), 32'd0);
        i_read = 1'b0;
        @(posedge clk); #1;
        d_write = 1'b0;
        chk("t2_idle", 32'({read, write}), 32'd0);

        // Single byte-lane write
        d_address = 32'd206; d_writedata = 32'd9; d_byteenable = 4'b0001; d_write = 1'b1;
        @(posedge clk); #1;
        chk("t6_byteenable", 32'(byteenable), 32'b0001);
        chk("t6_address", address, 32'd206);
        chk("t6_writedata", writedata, 32'd9);
        @(posedge clk); #1;
        chk("t6_done", 32'(d_waitrequest), 32'd0);
        @(posedge clk); #1;
        d_write = 1'b0;
        chk("t6_no_error", 32'(bus_error), 32'd0);

        // Watchdog abort on a hung fetch
        i_address = 32'hBFC00008; i_read = 1'b1; dir_wait = 1'b1;
        @(posedge clk); #1;
        chk("t4_granted", 32'(read), 32'd1);
        repeat (TO - 1) begin
            @(posedge clk); #1;
            chk("t4_hold_read", 32'(read), 32'd1);
        end
        @(posedge clk); #1;
        chk("t4_abort_read", 32'(read), 32'd0);
        chk("t4_abort_done", 32'(i_waitrequest), 32'd0);
        chk("t4_abort_data", i_readdata, ABORT);
        chk("t4_bus_error", 32'(bus_error), 32'd1);
        @(posedge clk); #1;
        i_read = 1'b0; dir_wait = 1'b0;
        @(posedge clk); #1;
        chk("t4_sticky", 32'(bus_error), 32'd1);
        reset = 1'b0;
        #2;
        chk("t4_reset_clears", 32'(bus_error), 32'd0);
        reset = 1'b1;

        // Random traffic from both requesters against the behavioural slave
        exp_err = 1'b0;
        sb_en = 1'b1;
        fork
            run_i(60);
            run_d(60);
        join
        repeat (5) @(posedge clk);
        #1;
        chk("end_i_exp_empty", i_exp_q.size(), 32'd0);
        chk("end_d_exp_empty", d_exp_q.size(), 32'd0);
        chk("end_i_bus_empty", i_slv_q.size(), 32'd0);
        chk("end_d_bus_empty", d_slv_q.size(), 32'd0);
        chk("end_bus_error", 32'(bus_error), 32'(exp_err));
        chk("end_idle", 32'({read, write}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
